// File: rtl/uart_pkg.sv
// UART shared definitions: FSM state encoding, default baud divisor, frame levels.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;

  // 100 MHz system clock / 115200 baud
  localparam int DEFAULT_CLKS_PER_BIT = 868;

  // Line levels of the framing bits; idle level equals the stop level
  localparam logic FRAME_START_BIT = 1'b0;
  localparam logic FRAME_STOP_BIT  = 1'b1;

endpackage

// File: rtl/baud_counter.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1, tick on the last cycle of each period.
// Latency: tick is combinational from the count, CLKS_PER_BIT cycles after clear drops.
// Backpressure: none; clear holds the count at zero while the line is idle.
module baud_counter
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam int            W    = $clog2(CLKS_PER_BIT);
  localparam logic [W-1:0]  LAST = W'(CLKS_PER_BIT - 1);

  logic [W-1:0] cnt;

  assign tick = (cnt == LAST);

  // Free-run while a frame is active; wrap at every bit boundary
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (clear || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/uart_tx_serializer.sv
// 8N1-style UART transmitter: start bit, N data bits LSB first, stop bit.
// Latency: start bit on tx one cycle after the accept edge; frame is (N+2)*CLKS_PER_BIT cycles.
// Backpressure: busy high from START to end of STOP; enable is ignored while busy.
module uart_tx_serializer
  import uart_pkg::*;
#(
  parameter int N            = 8,
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         enable,
  input  logic [N-1:0] data,
  output logic         busy,
  output logic         done,
  output logic         tx
);

  // Keep the index at least one bit wide so N=1 still elaborates
  localparam int           IW       = (N > 1) ? $clog2(N) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

  uart_state_e   state_q, state_d;
  logic [N-1:0]  shreg_q, shreg_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          tx_d, busy_d, done_d;
  logic          tick;

  baud_counter #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk  (clk),
    .reset(reset),
    .clear(state_q == IDLE),
    .tick (tick)
  );

  // State, datapath and all outputs registered; reset drops the line to idle at once
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      shreg_q <= '0;
      idx_q   <= '0;
      tx      <= FRAME_STOP_BIT;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      idx_q   <= idx_d;
      tx      <= tx_d;
      busy    <= busy_d;
      done    <= done_d;
    end
  end

  // Next state, shift/index update, and next line level derived from the next state
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    idx_d   = idx_q;
    done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        // busy is low exactly in IDLE, so enable here is an accept
        if (enable) begin
          state_d = START;
          shreg_d = data;
          idx_d   = '0;
        end
      end
      START: begin
        if (tick) begin
          state_d = DATA;
          idx_d   = '0;
        end
      end
      DATA: begin
        if (tick) begin
          shreg_d = shreg_q >> 1;
          if (idx_q == LAST_IDX) begin
            state_d = STOP;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      STOP: begin
        if (tick) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    tx_d = FRAME_STOP_BIT;
    case (state_d)
      START:   tx_d = FRAME_START_BIT;
      DATA:    tx_d = shreg_d[0];
      default: tx_d = FRAME_STOP_BIT;
    endcase

    busy_d = (state_d != IDLE);
  end

endmodule

// File: doc/uart_tx_serializer.md
# uart_tx_serializer

Serial transmitter for the message-display path. It accepts one N-bit character per handshake from the message-splitting FSM and shifts it out on the UART line as 8N1: one start bit, N data bits LSB first, one stop bit, no parity. It reports `busy` back to the FSM, which advances to the next character only while `busy` is low. Its `tx` output drives the board UART pin directly.

## Interface
Parameters:
- `N`, default 8: data bits per frame.
- `CLKS_PER_BIT`, default 868: clock cycles per bit (100 MHz / 115200 baud). Legal range is 2..65535.

Ports:
- `clk` input, 1 bit: system clock.
- `reset` input, 1 bit: asynchronous, active-low reset.
- `enable` input, 1 bit: transmit request. Qualifies `data`.
- `data` input, N bits: character to send.
- `busy` output, 1 bit: frame in progress. The block accepts no new character while it is high.
- `done` output, 1 bit: one-cycle pulse at the end of each stop bit.
- `tx` output, 1 bit: serial line. Idle level is 1.

## Operation
Reset (`reset`=0, takes effect immediately, independent of `clk`):
- `tx`=1, `busy`=0, `done`=0.
- State IDLE; bit counter and baud counter cleared.

Accept:
- A character is accepted on any rising edge where `enable`=1 and `busy`=0.
- `data` is copied into the shift register on that edge.
- `enable` while `busy`=1 is ignored.
- Changes on `data` after the accept edge have no effect on the frame in progress.

States:
- IDLE
  - `tx`=1.
  - Goes to START on accept.
- START
  - `tx`=0 for CLKS_PER_BIT cycles.
  - Then goes to DATA with bit index 0.
- DATA
  - `tx`=shift register bit 0 for CLKS_PER_BIT cycles.
  - Then the register shifts right and the index increments.
  - After bit N-1, goes to STOP.
- STOP
  - `tx`=1 for CLKS_PER_BIT cycles.
  - Then goes to IDLE with `done`=1 for that one cycle.

Counters:
- Baud counter width is clog2(CLKS_PER_BIT). It counts 0..CLKS_PER_BIT-1 and wraps to 0 at each bit boundary.
- Bit index width is clog2(N).

Outputs:
- `tx` is registered. No combinational path from any input to `tx`.
- `busy` is registered: high in START, DATA and STOP; low in IDLE.

Boundary cases:
- `enable` held high continuously: frames run back to back, separated by exactly one idle cycle (`tx`=1, `busy`=0).
- `reset` asserted mid-frame: the frame is aborted. `tx` returns to 1 immediately and no `done` pulse is produced.
- `reset` released on the same edge as `enable`=1: that edge does not accept. Acceptance starts from the first edge with `reset`=1 sampled.
- Illegal state encoding: returns to IDLE.

## Timing
- Edge k accepts the character:
  - `busy`=1 and `tx`=0 (start bit) from cycle k+1.
- Data bit i occupies cycles k+1+(i+1)·CLKS_PER_BIT through k+(i+2)·CLKS_PER_BIT.
- Stop bit ends at cycle k+(N+2)·CLKS_PER_BIT:
  - `busy` falls and `done` pulses on that same edge.
- Frame length is (N+2)·CLKS_PER_BIT cycles. The minimum accept-to-accept period is (N+2)·CLKS_PER_BIT+1 cycles.
- Upstream handshake:
  - An upstream FSM that advances on `busy`=0 moves on at the accept edge.
  - It sees `busy`=1 one cycle later and holds.
  - This is the intended behaviour: no character is lost or duplicated.

## Structure
- Shared package `uart_pkg`:
  - state encoding constants: IDLE=2'd0, START=2'd1, DATA=2'd2, STOP=2'd3;
  - default `CLKS_PER_BIT`;
  - frame-format constants (start=0, stop=1).
  - It is reused by the future receiver.
- One sub-module, `baud_counter`:
  - parameter CLKS_PER_BIT;
  - inputs `clk`, `reset`, `clear`;
  - output `tick` (high on the last cycle of each bit period).
  - It is also reused by the receiver.
- The shift register, bit index and FSM stay in `uart_tx_serializer`.

## Test plan
All scenarios use CLKS_PER_BIT=4 and N=8.
- Reset check: hold `reset`=0 for 3 cycles, then release. Required: `tx`=1, `busy`=0, `done`=0 throughout, and with `enable`=0 they stay so for 20 cycles.
- Single frame: `data`=8'h55, `enable` pulsed for 1 cycle. Required:
  - `tx` reads 0,1,0,1,0,1,0,1,0,1 per 4-cycle bit (start, LSB first), then stop bit 1;
  - `busy` high for exactly 40 cycles;
  - `done` high exactly once, on the cycle `busy` falls.
- Back to back: `enable` held at 1 with `data`=8'hA3, changed to 8'h0F at the first accept edge. Required:
  - first frame carries 0xA3 unaltered;
  - one idle cycle, then a second frame carrying 0x0F;
  - accept-to-accept period is 41 cycles.
- Ignored request: pulse `enable` with `data`=8'hFF at cycle 10 of a 0x00 frame. Required: 0x00 frame unchanged, no second frame, a single `done`.
- Mid-frame reset: assert `reset`=0 during data bit 3. Required: `tx`=1 and `busy`=0 immediately, without waiting for a clock edge, and no `done`. A fresh accept of 8'h81 after release produces a complete, correct frame.
- Upstream integration: drive from the 16-character splitting FSM with message "HELLO, ARTY A7!\n". Required: the decoded `tx` stream equals all 16 bytes in order with none dropped or repeated.
